sctrl_multi: RTL and testbench

//  Parametrised multi-channel sensor controller; successor of the single-sensor controller in the SoC top.
//  Per channel: captures 32-bit samples into a local buffer, throttles the sensor via sensor_en, raises an IRQ when full.
//  CPU side is a 1-cycle-latency register port; the bus wrapper (AXI slave3) is built on top of it.

---
 rtl/sctrl_pkg.sv | 27 ++
 rtl/sctrl_channel.sv | 128 ++++++++++++
 rtl/sctrl_multi.sv | 131 +++++++++++++
 tb/tb_sctrl_multi.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sctrl_pkg.sv
// Shared types and register map for the multi-channel sensor controller.
// Optional watermark support is enabled by defining SCTRL_WMARK_EN.
package sctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } ch_state_e;

  // Register indices inside a channel's register window (sel = 0)
  localparam int REG_CTRL   = 0;
  localparam int REG_CLEAR  = 1;
  localparam int REG_STATUS = 2;
  localparam int REG_WMARK  = 3;

  // CTRL field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MASK_BIT = 1;
  localparam int CTRL_W        = 2;

  // Channel-select field width; a single channel still gets one address bit
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sctrl_channel.sv
// One sensor channel: enable FSM, write pointer, sample buffer and raw interrupt.
// Define SCTRL_WMARK_EN to add the per-channel watermark register and watermark interrupt.
module sctrl_channel
  import sctrl_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_ctrl,
  input  logic              wr_clear,
  input  logic              wr_wmark,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_data,
  output logic              sensor_en,
  output logic              irq,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  wmark
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ch_state_e         state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  wptr_q, wptr_d;
  logic              sensor_en_q, sensor_en_d;
  logic              irq_q, irq_d;
  logic              capture;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

`ifdef SCTRL_WMARK_EN
  logic [CNT_W-1:0] wmark_q, wmark_d;

  always_comb begin
    wmark_d = wmark_q;
    if (wr_wmark) begin
      if (wdata == '0)
        wmark_d = CNT_W'(1);
      else if (wdata > DATA_W'(DEPTH))
        wmark_d = DEPTH_C;
      else
        wmark_d = wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wmark_q <= DEPTH_C;
    else       wmark_q <= wmark_d;
  end

  assign wmark = wmark_q;
`else
  logic unused_wmark;
  assign unused_wmark = wr_wmark ^ (^wdata[DATA_W-1:CTRL_W]);
  assign wmark        = '0;
`endif

  // State is fully determined by the post-edge enable and pointer, so a
  // re-enable with a full buffer lands straight back in FULL.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl)
      ctrl_d = wdata[CTRL_W-1:0];

    capture = (state_q == FILL) && sensor_ready && !wr_clear;

    wptr_d = wptr_q;
    if (wr_clear)
      wptr_d = '0;
    else if (capture)
      wptr_d = wptr_q + 1'b1;

    if (!ctrl_d[CTRL_EN_BIT])
      state_d = IDLE;
    else if (wptr_d == DEPTH_C)
      state_d = FULL;
    else
      state_d = FILL;

    sensor_en_d = (state_d == FILL);
`ifdef SCTRL_WMARK_EN
    irq_d = (state_d != IDLE) && (wptr_d >= wmark_d);
`else
    irq_d = (state_d == FULL);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      wptr_q      <= '0;
      sensor_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      wptr_q      <= wptr_d;
      sensor_en_q <= sensor_en_d;
      irq_q       <= irq_d;
    end
  end

  // Buffer contents are deliberately not reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (capture)
      mem[wptr_q[IDX_W-1:0]] <= sensor_data;
    if (rd_en)
      rd_data_q <= mem[rd_idx];
  end

  assign rd_data   = rd_data_q;
  assign sensor_en = sensor_en_q;
  assign irq       = irq_q;
  assign ctrl      = ctrl_q;
  assign count     = wptr_q;

endmodule

// File: rtl/sctrl_multi.sv
// Multi-channel sensor controller: register decode, read mux and interrupt combine.
// Build option SCTRL_WMARK_EN enables the per-channel watermark register.
module sctrl_multi
  import sctrl_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 64,
  parameter int DATA_W  = 32,
  localparam int CH_W   = ch_width(NUM_CH),
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int ADDR_W = CH_W + 1 + IDX_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  input  logic [NUM_CH-1:0]        sensor_ready,
  input  logic [NUM_CH*DATA_W-1:0] sensor_out,
  output logic [NUM_CH-1:0]        sensor_en,
  output logic [NUM_CH-1:0]        ch_irq,
  output logic                     sensor_interrupt
);

  localparam int CNT_W = IDX_W + 1;
  localparam int SLOTS = 1 << CH_W;

  logic [CH_W-1:0]   a_ch;
  logic              a_sel;
  logic [IDX_W-1:0]  a_idx;
  logic              reg_wr;

  logic [NUM_CH-1:0] ch_mask;
  logic [CTRL_W-1:0] slot_ctrl  [SLOTS];
  logic [CNT_W-1:0]  slot_count [SLOTS];
  logic [CNT_W-1:0]  slot_wmark [SLOTS];
  logic [DATA_W-1:0] slot_rdata [SLOTS];

  logic              rvalid_q, rvalid_d;
  logic              rd_sel_q, rd_sel_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [DATA_W-1:0] reg_rdata_q, reg_rdata_d;
  logic              sensor_interrupt_q, sensor_interrupt_d;

  assign a_ch   = addr[ADDR_W-1 -: CH_W];
  assign a_sel  = addr[IDX_W];
  assign a_idx  = addr[IDX_W-1:0];
  assign reg_wr = req && we && !a_sel;

  // Address slots past NUM_CH are tied to zero so they read back 0 and absorb writes
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : gen_slot
      if (gi < NUM_CH) begin : gen_ch
        logic hit;
        assign hit = (a_ch == CH_W'(gi));

        sctrl_channel #(
          .DEPTH  (DEPTH),
          .DATA_W (DATA_W)
        ) u_ch (
          .clk          (clk),
          .rstn         (rstn),
          .wr_ctrl      (reg_wr && hit && (a_idx == IDX_W'(REG_CTRL))),
          .wr_clear     (reg_wr && hit && (a_idx == IDX_W'(REG_CLEAR))),
          .wr_wmark     (reg_wr && hit && (a_idx == IDX_W'(REG_WMARK))),
          .wdata        (wdata),
          .rd_en        (req && !we && a_sel && hit),
          .rd_idx       (a_idx),
          .rd_data      (slot_rdata[gi]),
          .sensor_ready (sensor_ready[gi]),
          .sensor_data  (sensor_out[gi*DATA_W +: DATA_W]),
          .sensor_en    (sensor_en[gi]),
          .irq          (ch_irq[gi]),
          .ctrl         (slot_ctrl[gi]),
          .count        (slot_count[gi]),
          .wmark        (slot_wmark[gi])
        );

        assign ch_mask[gi] = slot_ctrl[gi][CTRL_MASK_BIT];
      end else begin : gen_empty
        assign slot_ctrl[gi]  = '0;
        assign slot_count[gi] = '0;
        assign slot_wmark[gi] = '0;
        assign slot_rdata[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    reg_rdata_d = '0;
    case (a_idx)
      IDX_W'(REG_CTRL):   reg_rdata_d[CTRL_W-1:0] = slot_ctrl[a_ch];
      IDX_W'(REG_STATUS): begin
        reg_rdata_d[CNT_W-1:0] = slot_count[a_ch];
        reg_rdata_d[DATA_W-1]  = (slot_count[a_ch] == CNT_W'(DEPTH));
      end
      IDX_W'(REG_WMARK):  reg_rdata_d[CNT_W-1:0] = slot_wmark[a_ch];
      default: ;
    endcase

    rvalid_d           = req && !we;
    rd_sel_d           = a_sel;
    rd_ch_d            = a_ch;
    sensor_interrupt_d = |(ch_irq & ch_mask);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q           <= 1'b0;
      rd_sel_q           <= 1'b0;
      rd_ch_q            <= '0;
      reg_rdata_q        <= '0;
      sensor_interrupt_q <= 1'b0;
    end else begin
      rvalid_q           <= rvalid_d;
      rd_sel_q           <= rd_sel_d;
      rd_ch_q            <= rd_ch_d;
      reg_rdata_q        <= reg_rdata_d;
      sensor_interrupt_q <= sensor_interrupt_d;
    end
  end

  // Buffer data comes straight from the channel's registered RAM read
  assign rdata = !rvalid_q ? '0 : (rd_sel_q ? slot_rdata[rd_ch_q] : reg_rdata_q);
  assign rvalid           = rvalid_q;
  assign sensor_interrupt = sensor_interrupt_q;

endmodule

// File: tb/tb_sctrl_multi.sv
// Testbench for sctrl_multi (NUM_CH=2, DEPTH=8): directed scenarios plus random traffic
// against a behavioural model. Watermark checks are compiled in when SCTRL_WMARK_EN is defined.
module tb_sctrl_multi;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     req = 1'b0;
  logic                     we = 1'b0;
  logic [ADDR_W-1:0]        addr = '0;
  logic [DATA_W-1:0]        wdata = '0;
  logic [DATA_W-1:0]        rdata;
  logic                     rvalid;
  logic [NUM_CH-1:0]        sensor_ready = '0;
  logic [NUM_CH*DATA_W-1:0] sensor_out = '0;
  logic [NUM_CH-1:0]        sensor_en;
  logic [NUM_CH-1:0]        ch_irq;
  logic                     sensor_interrupt;

  int n_cmp = 0;
  int n_bad = 0;

  sctrl_multi #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req              (req),
    .we               (we),
    .addr             (addr),
    .wdata            (wdata),
    .rdata            (rdata),
    .rvalid           (rvalid),
    .sensor_ready     (sensor_ready),
    .sensor_out       (sensor_out),
    .sensor_en        (sensor_en),
    .ch_irq           (ch_irq),
    .sensor_interrupt (sensor_interrupt)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-channel enable/mask bits, fill count and buffer image
  bit          m_en    [NUM_CH];
  bit          m_mask  [NUM_CH];
  int          m_count [NUM_CH];
  int          m_wmark [NUM_CH];
  logic [31:0] m_buf   [NUM_CH][DEPTH];
  bit          m_known [NUM_CH][DEPTH];
  bit          e_int;
  bit          e_rvalid;
  bit          e_rknown;
  logic [31:0] e_rdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_sen(input int c);
    return m_en[c] && (m_count[c] < DEPTH);
  endfunction

  function automatic bit m_irq(input int c);
    return m_en[c] && (m_count[c] >= m_wmark[c]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_mask[c] = 0; m_count[c] = 0; m_wmark[c] = DEPTH;
    end
    e_int = 0; e_rvalid = 0; e_rknown = 1; e_rdata = '0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs present at that edge
  task automatic model_step();
    bit new_int;
    int ch, idx;
    bit sel, is_clr;
    logic [31:0] v;
    ch  = int'(addr[4]);
    sel = addr[3];
    idx = int'(addr[2:0]);
    new_int = 0;
    for (int c = 0; c < NUM_CH; c++) new_int |= m_irq(c) && m_mask[c];

    e_rvalid = req && !we;
    e_rknown = 1;
    e_rdata  = '0;
    if (req && !we) begin
      if (sel) begin
        e_rdata  = m_buf[ch][idx];
        e_rknown = m_known[ch][idx];
      end else if (idx == 0) begin
        e_rdata = {30'd0, m_mask[ch], m_en[ch]};
      end else if (idx == 2) begin
        e_rdata = 32'(m_count[ch]);
        if (m_count[ch] == DEPTH) e_rdata[31] = 1'b1;
      end else if (idx == 3) begin
`ifdef SCTRL_WMARK_EN
        e_rdata = 32'(m_wmark[ch]);
`else
        e_rdata = '0;
`endif
      end
    end

    for (int c = 0; c < NUM_CH; c++) begin
      is_clr = req && we && !sel && (ch == c) && (idx == 1);
      if (m_sen(c) && sensor_ready[c] && !is_clr) begin
        m_buf[c][m_count[c]]   = sensor_out[c*DATA_W +: DATA_W];
        m_known[c][m_count[c]] = 1;
        m_count[c]++;
      end
    end

    if (req && we && !sel) begin
      if (idx == 0) begin
        m_en[ch] = wdata[0]; m_mask[ch] = wdata[1];
      end else if (idx == 1) begin
        m_count[ch] = 0;
      end else if (idx == 3) begin
`ifdef SCTRL_WMARK_EN
        v = wdata;
        if (v == 0) m_wmark[ch] = 1;
        else if (v > DEPTH) m_wmark[ch] = DEPTH;
        else m_wmark[ch] = int'(v);
`endif
      end
    end
    e_int = new_int;
  endtask

  task automatic tick();
    logic [1:0] e_sen, e_irq;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_sen[c] = m_sen(c);
      e_irq[c] = m_irq(c);
    end
    check_val("sensor_en", 32'(sensor_en), 32'(e_sen));
    check_val("ch_irq", 32'(ch_irq), 32'(e_irq));
    check_val("sensor_interrupt", 32'(sensor_interrupt), 32'(e_int));
    check_val("rvalid", 32'(rvalid), 32'(e_rvalid));
    if (e_rvalid && e_rknown) check_val("rdata", rdata, e_rdata);
    if (req)
      $display("[%0t] %s ch%0d %s idx=%0d wdata=%08h rdata=%08h", $time, we ? "WR" : "RD",
               addr[4], addr[3] ? "buf" : "reg", addr[2:0], wdata, rdata);
    req = 0; we = 0; sensor_ready = '0;
  endtask

  task automatic cpu_wr(input int ch, input int sel, input int idx, input logic [31:0] d);
    req = 1; we = 1; wdata = d;
    addr = {1'(ch), 1'(sel), 3'(idx)};
    tick();
  endtask

  task automatic cpu_rd(input int ch, input int sel, input int idx, output logic [31:0] v);
    req = 1; we = 0;
    addr = {1'(ch), 1'(sel), 3'(idx)};
    tick();
    v = rdata;
  endtask

  task automatic pulse(input int c, input logic [31:0] d);
    sensor_ready[c] = 1'b1;
    sensor_out[c*DATA_W +: DATA_W] = d;
    tick();
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check_val("arst_sensor_en", 32'(sensor_en), 0);
    check_val("arst_ch_irq", 32'(ch_irq), 0);
    check_val("arst_interrupt", 32'(sensor_interrupt), 0);
    check_val("arst_rvalid", 32'(rvalid), 0);
    check_val("arst_rdata", rdata, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < DEPTH; i++) m_known[c][i] = 0;
    model_reset();

    #2;
    check_val("rst_sensor_en", 32'(sensor_en), 0);
    check_val("rst_ch_irq", 32'(ch_irq), 0);
    check_val("rst_interrupt", 32'(sensor_interrupt), 0);
    check_val("rst_rvalid", 32'(rvalid), 0);
    check_val("rst_rdata", rdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset in the middle of a fill
    cpu_wr(0, 0, 0, 32'h1);
    for (int i = 0; i < 5; i++) pulse(0, 32'h100 + 32'(i));
    cpu_rd(0, 0, 2, v);
    check_val("prerst_count", v, 5);
    do_reset();
    cpu_rd(0, 0, 2, v);
    check_val("postrst_status", v, 0);
    check_val("postrst_sen0", 32'(sensor_en[0]), 0);

    // Full fill of channel 0
    cpu_wr(0, 0, 0, 32'h1);
    for (int i = 0; i < DEPTH; i++) pulse(0, 32'hA0 + 32'(i));
    check_val("full_sen0", 32'(sensor_en[0]), 0);
    check_val("full_irq0", 32'(ch_irq[0]), 1);
    cpu_rd(0, 0, 2, v);
    check_val("full_status0", v, 32'h8000_0008);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_rd(0, 1, i, v);
      check_val("buf0", v, 32'hA0 + 32'(i));
    end
    pulse(0, 32'hBAD);

    // Channel 1 masked interrupt, then unmask
    cpu_wr(1, 0, 0, 32'h1);
    for (int i = 0; i < DEPTH; i++) pulse(1, 32'hB0 + 32'(i));
    check_val("ch1_irq", 32'(ch_irq[1]), 1);
    check_val("ch1_int_masked", 32'(sensor_interrupt), 0);
    cpu_wr(1, 0, 0, 32'h3);
    check_val("ch1_int_lag", 32'(sensor_interrupt), 0);
    tick();
    check_val("ch1_int_on", 32'(sensor_interrupt), 1);

    // CLEAR colliding with a capture
    cpu_wr(0, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) pulse(0, 32'hC0 + 32'(i));
    sensor_ready[0] = 1'b1;
    sensor_out[DATA_W-1:0] = 32'hDEAD;
    cpu_wr(0, 0, 1, 32'h0);
    check_val("clr_irq0", 32'(ch_irq[0]), 0);
    check_val("clr_sen0", 32'(sensor_en[0]), 1);
    cpu_rd(0, 0, 2, v);
    check_val("clr_status0", v, 0);
    pulse(0, 32'h55);
    cpu_rd(0, 1, 0, v);
    check_val("clr_buf0", v, 32'h55);

    // Disable at count 4, ignored samples, resume at idx 4
    for (int i = 0; i < 3; i++) pulse(0, 32'hD0 + 32'(i));
    cpu_wr(0, 0, 0, 32'h0);
    pulse(0, 32'hEE0);
    pulse(0, 32'hEE1);
    cpu_rd(0, 0, 2, v);
    check_val("dis_count", v, 4);
    cpu_wr(0, 0, 0, 32'h1);
    pulse(0, 32'h77);
    cpu_rd(0, 1, 4, v);
    check_val("resume_buf4", v, 32'h77);
    cpu_rd(0, 0, 2, v);
    check_val("resume_count", v, 5);

`ifdef SCTRL_WMARK_EN
    cpu_wr(0, 0, 3, 32'h0);
    cpu_rd(0, 0, 3, v);
    check_val("wmark_zero", v, 1);
    cpu_wr(0, 0, 3, 32'd100);
    cpu_rd(0, 0, 3, v);
    check_val("wmark_clamp", v, DEPTH);
    cpu_wr(1, 0, 3, 32'd3);
    cpu_wr(1, 0, 1, 32'h0);
    pulse(1, 32'h1);
    pulse(1, 32'h2);
    check_val("wm_irq_before", 32'(ch_irq[1]), 0);
    pulse(1, 32'h3);
    check_val("wm_irq_at3", 32'(ch_irq[1]), 1);
    check_val("wm_sen_at3", 32'(sensor_en[1]), 1);
    for (int i = 3; i < DEPTH; i++) pulse(1, 32'(i + 1));
    check_val("wm_sen_full", 32'(sensor_en[1]), 0);
`else
    cpu_wr(0, 0, 3, 32'h5);
    cpu_rd(0, 0, 3, v);
    check_val("wmark_absent", v, 0);
`endif

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        req   = 1'b1;
        we    = 1'($urandom_range(0, 1));
        addr  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
        wdata = $urandom();
        if (we && !addr[3] && addr[2:0] == 3'd1 && $urandom_range(0, 3) != 0) we = 1'b0;
        if (we && !addr[3] && addr[2:0] == 3'd0) wdata[0] = ($urandom_range(0, 3) != 0);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        sensor_ready[c] = 1'($urandom_range(0, 1));
        sensor_out[c*DATA_W +: DATA_W] = $urandom();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
